// File: rtl/qracc_bank_rw_ctrl.sv
// Single-row read/write sequencer for the multibank QRAcc SRAM: PCH -> WL/CSEL -> SAEN -> response.
// Optional write-verify read-back is enabled with the QRACC_WRITE_VERIFY_EN macro.
module qracc_bank_rw_ctrl #(
    parameter int numRows   = 128,
    parameter int numCols   = 8,
    parameter int numBanks  = 8,
    parameter int pchCycles = 2,
    parameter int wlCycles  = 2,
    // One extra bank-index bit so out-of-range indices (>= numBanks) can be presented.
    localparam int BANK_W   = $clog2(numBanks + 1),
    localparam int ROW_W    = $clog2(numRows)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [BANK_W-1:0]   req_bank,
    input  logic [ROW_W-1:0]    req_row,
    input  logic [numCols-1:0]  req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [numCols-1:0]  rsp_data,
    output logic                rsp_err,
    output logic [numBanks-1:0] bank_select,
    output logic [numRows-1:0]  WL,
    output logic                PCH,
    output logic                WRITE,
    output logic [numCols-1:0]  WR_DATA,
    output logic [numCols-1:0]  CSEL,
    output logic                SAEN,
    input  logic [numCols-1:0]  SA_OUT
);

    localparam int MAX_CYC = (pchCycles > wlCycles) ? pchCycles : wlCycles;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PRECH  = 3'd1;
    localparam logic [2:0] ACCESS = 3'd2;
    localparam logic [2:0] SENSE  = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;
`ifdef QRACC_WRITE_VERIFY_EN
    localparam logic [2:0] VPRECH = 3'd5;
`endif

    logic [2:0]          state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                write_reg;
    logic                verify_reg;
    logic [numCols-1:0]  wdata_reg;
    logic [numRows-1:0]  row_oh_reg;

    logic [numBanks-1:0] bank_dec;
    logic [numRows-1:0]  row_dec;
    logic                bank_ok;

    genvar gi;
    generate
        for (gi = 0; gi < numBanks; gi++) begin : g_bank_dec
            assign bank_dec[gi] = (req_bank == BANK_W'(gi));
        end
        for (gi = 0; gi < numRows; gi++) begin : g_row_dec
            assign row_dec[gi] = (req_row == ROW_W'(gi));
        end
    endgenerate

    assign bank_ok = (req_bank < BANK_W'(numBanks));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            write_reg   <= 1'b0;
            verify_reg  <= 1'b0;
            wdata_reg   <= '0;
            row_oh_reg  <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            bank_select <= '0;
            WL          <= '0;
            PCH         <= 1'b0;
            WRITE       <= 1'b0;
            WR_DATA     <= '0;
            CSEL        <= '0;
            SAEN        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg  <= req_write;
                        wdata_reg  <= req_wdata;
                        row_oh_reg <= row_dec;
                        verify_reg <= 1'b0;
                        if (bank_ok) begin
                            req_ready   <= 1'b0;
                            PCH         <= 1'b1;
                            bank_select <= bank_dec;
                            cnt_reg     <= CNT_W'(pchCycles - 1);
                            state_reg   <= PRECH;
                        end else begin
                            // Bad bank: no analog activity, error response where one is owed.
`ifdef QRACC_WRITE_VERIFY_EN
                            req_ready <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            state_reg <= RESP;
`else
                            if (!req_write) begin
                                req_ready <= 1'b0;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                                rsp_data  <= '0;
                                state_reg <= RESP;
                            end
`endif
                        end
                    end
                end

`ifdef QRACC_WRITE_VERIFY_EN
                PRECH, VPRECH: begin
`else
                PRECH: begin
`endif
                    if (cnt_reg == '0) begin
                        PCH       <= 1'b0;
                        WL        <= row_oh_reg;
                        CSEL      <= '1;
                        cnt_reg   <= CNT_W'(wlCycles - 1);
                        state_reg <= ACCESS;
                        if (write_reg && !verify_reg) begin
                            WRITE   <= 1'b1;
                            WR_DATA <= wdata_reg;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                ACCESS: begin
                    if (cnt_reg == '0) begin
                        WRITE   <= 1'b0;
                        WR_DATA <= '0;
                        if (write_reg && !verify_reg) begin
                            WL   <= '0;
                            CSEL <= '0;
`ifdef QRACC_WRITE_VERIFY_EN
                            PCH        <= 1'b1;
                            verify_reg <= 1'b1;
                            cnt_reg    <= CNT_W'(pchCycles - 1);
                            state_reg  <= VPRECH;
`else
                            bank_select <= '0;
                            req_ready   <= 1'b1;
                            state_reg   <= IDLE;
`endif
                        end else begin
                            SAEN      <= 1'b1;
                            state_reg <= SENSE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                SENSE: begin
                    SAEN        <= 1'b0;
                    WL          <= '0;
                    CSEL        <= '0;
                    bank_select <= '0;
                    rsp_data    <= SA_OUT;
                    rsp_err     <= verify_reg && (SA_OUT != wdata_reg);
                    rsp_valid   <= 1'b1;
                    state_reg   <= RESP;
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        rsp_err    <= 1'b0;
                        rsp_data   <= '0;
                        verify_reg <= 1'b0;
                        req_ready  <= 1'b1;
                        state_reg  <= IDLE;
                    end
                end

                default: begin
                    state_reg   <= IDLE;
                    req_ready   <= 1'b1;
                    rsp_valid   <= 1'b0;
                    rsp_err     <= 1'b0;
                    bank_select <= '0;
                    WL          <= '0;
                    PCH         <= 1'b0;
                    WRITE       <= 1'b0;
                    WR_DATA     <= '0;
                    CSEL        <= '0;
                    SAEN        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qracc_bank_rw_ctrl.sv
// Directed bench for qracc_bank_rw_ctrl: read, write, backpressure, bad bank and mid-transaction reset.
`timescale 1ns/1ps
module tb_qracc_bank_rw_ctrl;

    logic         CLK = 1'b0;
    logic         RST;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [3:0]   req_bank;
    logic [6:0]   req_row;
    logic [7:0]   req_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [7:0]   rsp_data;
    logic         rsp_err;
    logic [7:0]   bank_select;
    logic [127:0] WL;
    logic         PCH;
    logic         WRITE;
    logic [7:0]   WR_DATA;
    logic [7:0]   CSEL;
    logic         SAEN;
    logic [7:0]   SA_OUT;

    int n_checks = 0;
    int n_fail   = 0;

    qracc_bank_rw_ctrl #(
        .numRows(128), .numCols(8), .numBanks(8), .pchCycles(2), .wlCycles(2)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_bank(req_bank), .req_row(req_row), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .bank_select(bank_select), .WL(WL), .PCH(PCH), .WRITE(WRITE),
        .WR_DATA(WR_DATA), .CSEL(CSEL), .SAEN(SAEN), .SA_OUT(SA_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".pch"},  PCH, 1'b0);
        check({tag, ".wl"},   WL, '0);
        check({tag, ".bank"}, bank_select, 8'h00);
        check({tag, ".saen"}, SAEN, 1'b0);
        check({tag, ".wr"},   WRITE, 1'b0);
    endtask

    // Present a request and return in cycle 1 (just after the acceptance edge).
    task automatic issue(input logic wr, input logic [3:0] bank, input logic [6:0] row,
                         input logic [7:0] wdata);
        check("issue.req_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = wr;
        req_bank  = bank;
        req_row   = row;
        req_wdata = wdata;
        step();
        req_valid = 1'b0;
    endtask

    // Read from cycle 1 through the response in cycle 6, then consume it.
    task automatic read_txn(input string tag, input logic [3:0] bank, input logic [6:0] row,
                            input logic [7:0] sa);
        SA_OUT = sa;
        issue(1'b0, bank, row, 8'h00);
        check({tag, ".c1.pch"}, PCH, 1'b1);
        step(); step();
        check({tag, ".c3.wl"}, WL, 128'd1 << row);
        step(); step();
        check({tag, ".c5.saen"}, SAEN, 1'b1);
        step();
        check({tag, ".c6.valid"}, rsp_valid, 1'b1);
        check({tag, ".c6.data"}, rsp_data, sa);
        check({tag, ".c6.err"}, rsp_err, 1'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, ".done.ready"}, req_ready, 1'b1);
    endtask

    initial begin
        RST = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_bank = 4'd1; req_row = 7'd0;
        req_wdata = 8'h00; rsp_ready = 1'b0; SA_OUT = 8'h00;

        // Reset held 3 cycles with a request pending.
        step(); step(); step();
        check_quiet("rst");
        check("rst.req_ready", req_ready, 1'b1);
        check("rst.rsp_valid", rsp_valid, 1'b0);
        check("rst.rsp_data", rsp_data, 8'h00);
        check("rst.rsp_err", rsp_err, 1'b0);
        check("rst.csel", CSEL, 8'h00);
        check("rst.wr_data", WR_DATA, 8'h00);
        RST = 1'b0; req_valid = 1'b0;
        step();
        check("rst.no_accept", PCH, 1'b0);

        // Read bank 3 row 5, full cycle-by-cycle check.
        SA_OUT = 8'hA5;
        issue(1'b0, 4'd3, 7'd5, 8'h00);
        for (int c = 1; c <= 2; c++) begin
            check($sformatf("rd.c%0d.pch", c), PCH, 1'b1);
            check($sformatf("rd.c%0d.bank", c), bank_select, 8'h08);
            check($sformatf("rd.c%0d.wl", c), WL, '0);
            check($sformatf("rd.c%0d.ready", c), req_ready, 1'b0);
            step();
        end
        for (int c = 3; c <= 4; c++) begin
            check($sformatf("rd.c%0d.pch", c), PCH, 1'b0);
            check($sformatf("rd.c%0d.wl", c), WL, 128'd1 << 5);
            check($sformatf("rd.c%0d.csel", c), CSEL, 8'hFF);
            check($sformatf("rd.c%0d.bank", c), bank_select, 8'h08);
            check($sformatf("rd.c%0d.write", c), WRITE, 1'b0);
            check($sformatf("rd.c%0d.saen", c), SAEN, 1'b0);
            step();
        end
        check("rd.c5.saen", SAEN, 1'b1);
        check("rd.c5.wl", WL, 128'd1 << 5);
        check("rd.c5.pch", PCH, 1'b0);
        check("rd.c5.valid", rsp_valid, 1'b0);
        step();
        SA_OUT = 8'h00;
        // Backpressure: response must hold for 4 cycles with the array idle.
        for (int c = 6; c <= 9; c++) begin
            check($sformatf("rd.c%0d.valid", c), rsp_valid, 1'b1);
            check($sformatf("rd.c%0d.data", c), rsp_data, 8'hA5);
            check($sformatf("rd.c%0d.err", c), rsp_err, 1'b0);
            check($sformatf("rd.c%0d.ready", c), req_ready, 1'b0);
            check_quiet($sformatf("rd.c%0d", c));
            if (c < 9) step();
        end
        // Consume while a new request waits: it must not be taken on the same edge.
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_bank = 4'd0; req_row = 7'd0;
        step();
        rsp_ready = 1'b0;
        check("hs.valid", rsp_valid, 1'b0);
        check("hs.req_ready", req_ready, 1'b1);
        check("hs.no_accept", PCH, 1'b0);
        SA_OUT = 8'h5A;
        step();
        req_valid = 1'b0;
        check("rd2.c1.pch", PCH, 1'b1);
        check("rd2.c1.bank", bank_select, 8'h01);
        step(); step(); step(); step(); step();
        check("rd2.c6.valid", rsp_valid, 1'b1);
        check("rd2.c6.data", rsp_data, 8'h5A);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Write bank 7 row 127.
        SA_OUT = 8'h3D;
        issue(1'b1, 4'd7, 7'd127, 8'h3C);
        check("wr.c1.bank", bank_select, 8'h80);
        check("wr.c1.pch", PCH, 1'b1);
        check("wr.c1.write", WRITE, 1'b0);
        step(); step();
        for (int c = 3; c <= 4; c++) begin
            check($sformatf("wr.c%0d.write", c), WRITE, 1'b1);
            check($sformatf("wr.c%0d.wr_data", c), WR_DATA, 8'h3C);
            check($sformatf("wr.c%0d.csel", c), CSEL, 8'hFF);
            check($sformatf("wr.c%0d.wl", c), WL, 128'd1 << 127);
            check($sformatf("wr.c%0d.pch", c), PCH, 1'b0);
            step();
        end
`ifdef QRACC_WRITE_VERIFY_EN
        check("wv.c5.pch", PCH, 1'b1);
        check("wv.c5.write", WRITE, 1'b0);
        step(); step();
        check("wv.c7.wl", WL, 128'd1 << 127);
        check("wv.c7.write", WRITE, 1'b0);
        step(); step();
        check("wv.c9.saen", SAEN, 1'b1);
        step();
        check("wv.c10.valid", rsp_valid, 1'b1);
        check("wv.c10.err", rsp_err, 1'b1);
        check("wv.c10.data", rsp_data, 8'h3D);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("wv.done.ready", req_ready, 1'b1);
`else
        check("wr.c5.req_ready", req_ready, 1'b1);
        check("wr.c5.rsp_valid", rsp_valid, 1'b0);
        check("wr.c5.write", WRITE, 1'b0);
        check("wr.c5.wr_data", WR_DATA, 8'h00);
        check("wr.c5.bank", bank_select, 8'h00);
`endif
        SA_OUT = 8'h00;

        // Out-of-range read: error response in cycle 1, no analog activity.
        SA_OUT = 8'hFF;
        issue(1'b0, 4'd8, 7'd9, 8'h00);
        check_quiet("oor.c1");
        check("oor.c1.valid", rsp_valid, 1'b1);
        check("oor.c1.err", rsp_err, 1'b1);
        check("oor.c1.data", rsp_data, 8'h00);
        check("oor.c1.ready", req_ready, 1'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("oor.done.ready", req_ready, 1'b1);
        check("oor.done.err", rsp_err, 1'b0);

        // Out-of-range write.
        issue(1'b1, 4'd12, 7'd3, 8'h77);
        check_quiet("oorw.c1");
`ifdef QRACC_WRITE_VERIFY_EN
        check("oorw.c1.valid", rsp_valid, 1'b1);
        check("oorw.c1.err", rsp_err, 1'b1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
`else
        check("oorw.c1.valid", rsp_valid, 1'b0);
        check("oorw.c1.ready", req_ready, 1'b1);
`endif

        // Reset during cycle 3 of a read, then a clean read afterwards.
        SA_OUT = 8'h99;
        issue(1'b0, 4'd4, 7'd64, 8'h00);
        step(); step();
        check("mrst.c3.wl", WL, 128'd1 << 64);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_quiet("mrst");
        check("mrst.csel", CSEL, 8'h00);
        check("mrst.req_ready", req_ready, 1'b1);
        check("mrst.rsp_valid", rsp_valid, 1'b0);
        step(); step(); step(); step();
        check("mrst.stays_idle", rsp_valid, 1'b0);
        read_txn("post", 4'd2, 7'd1, 8'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
